// File: rtl/plic_tl_buffer.sv
// plic_tl_buffer: registered TL-UL A/D decoupling FIFOs in front of the PLIC plus interrupt pass-through.
// Define PLIC_BUF_INT_SYNC_EN to route int_in through a 2-flop synchronizer (default: combinational wire).

module plic_tl_buffer_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             enq;
  logic             deq;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes come only from the count register; reset input masks them while asserted.
  assign in_ready  = reset & (count != FULL_CNT);
  assign out_valid = reset & (count != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= next_ptr(tail);
      if (deq) head <= next_ptr(head);
      if (enq && !deq) begin
        count <= count + CNT_W'(1);
      end else if (!enq && deq) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage holds payload only; stale entries are hidden by the count.
  always_ff @(posedge clock) begin
    if (enq) mem[tail] <= in_bits;
  end

  assign out_bits = out_valid ? mem[head] : '0;
endmodule

module plic_tl_buffer #(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_a_valid,
  output logic        in_a_ready,
  input  logic [2:0]  in_a_bits_opcode,
  input  logic [2:0]  in_a_bits_param,
  input  logic [1:0]  in_a_bits_size,
  input  logic [10:0] in_a_bits_source,
  input  logic [27:0] in_a_bits_address,
  input  logic [7:0]  in_a_bits_mask,
  input  logic [63:0] in_a_bits_data,
  input  logic        in_a_bits_corrupt,
  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_bits_opcode,
  output logic [2:0]  out_a_bits_param,
  output logic [1:0]  out_a_bits_size,
  output logic [10:0] out_a_bits_source,
  output logic [27:0] out_a_bits_address,
  output logic [7:0]  out_a_bits_mask,
  output logic [63:0] out_a_bits_data,
  output logic        out_a_bits_corrupt,
  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_bits_opcode,
  input  logic [1:0]  out_d_bits_size,
  input  logic [10:0] out_d_bits_source,
  input  logic [63:0] out_d_bits_data,
  output logic        in_d_valid,
  input  logic        in_d_ready,
  output logic [2:0]  in_d_bits_opcode,
  output logic [1:0]  in_d_bits_size,
  output logic [10:0] in_d_bits_source,
  output logic [63:0] in_d_bits_data,
  input  logic        int_in,
  output logic        int_out
);
  localparam int A_W = 3 + 3 + 2 + 11 + 28 + 8 + 64 + 1;
  localparam int D_W = 3 + 2 + 11 + 64;

  logic [A_W-1:0] a_enq_bits;
  logic [A_W-1:0] a_deq_bits;
  logic [D_W-1:0] d_enq_bits;
  logic [D_W-1:0] d_deq_bits;

  // Payload is packed verbatim; no field is interpreted or altered.
  assign a_enq_bits = {in_a_bits_opcode, in_a_bits_param, in_a_bits_size, in_a_bits_source,
                       in_a_bits_address, in_a_bits_mask, in_a_bits_data, in_a_bits_corrupt};
  assign {out_a_bits_opcode, out_a_bits_param, out_a_bits_size, out_a_bits_source,
          out_a_bits_address, out_a_bits_mask, out_a_bits_data, out_a_bits_corrupt} = a_deq_bits;

  assign d_enq_bits = {out_d_bits_opcode, out_d_bits_size, out_d_bits_source, out_d_bits_data};
  assign {in_d_bits_opcode, in_d_bits_size, in_d_bits_source, in_d_bits_data} = d_deq_bits;

  plic_tl_buffer_fifo #(
    .DEPTH (A_DEPTH),
    .WIDTH (A_W)
  ) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_a_valid),
    .in_ready  (in_a_ready),
    .in_bits   (a_enq_bits),
    .out_valid (out_a_valid),
    .out_ready (out_a_ready),
    .out_bits  (a_deq_bits)
  );

  plic_tl_buffer_fifo #(
    .DEPTH (D_DEPTH),
    .WIDTH (D_W)
  ) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (out_d_valid),
    .in_ready  (out_d_ready),
    .in_bits   (d_enq_bits),
    .out_valid (in_d_valid),
    .out_ready (in_d_ready),
    .out_bits  (d_deq_bits)
  );

`ifdef PLIC_BUF_INT_SYNC_EN
  logic int_sync_p0;
  logic int_sync_p1;

  // Stage p0 -> p1: two-flop level synchronizer, exactly two cycles of latency.
  always_ff @(posedge clock) begin
    if (!reset) begin
      int_sync_p0 <= 1'b0;
      int_sync_p1 <= 1'b0;
    end else begin
      int_sync_p0 <= int_in;
      int_sync_p1 <= int_sync_p0;
    end
  end

  assign int_out = int_sync_p1;
`else
  assign int_out = int_in;
`endif
endmodule

// File: tb/tb_plic_tl_buffer.sv
// Self-checking bench for plic_tl_buffer: scoreboard queues for A/D beats, per-scenario tasks.
module tb_plic_tl_buffer;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         in_a_valid, out_a_ready, out_d_valid, in_d_ready, int_in;
  logic [119:0] a_in;
  logic [79:0]  d_in;

  logic [2:0]  ia_opcode, ia_param;
  logic [1:0]  ia_size;
  logic [10:0] ia_source;
  logic [27:0] ia_address;
  logic [7:0]  ia_mask;
  logic [63:0] ia_data;
  logic        ia_corrupt;
  logic [2:0]  od_opcode;
  logic [1:0]  od_size;
  logic [10:0] od_source;
  logic [63:0] od_data;
  assign {ia_opcode, ia_param, ia_size, ia_source, ia_address, ia_mask, ia_data, ia_corrupt} = a_in;
  assign {od_opcode, od_size, od_source, od_data} = d_in;

  // Outputs of the A_DEPTH=2 instance
  logic        in_a_ready, out_a_valid, out_d_ready, in_d_valid, int_out;
  logic [2:0]  oa_opcode, oa_param;
  logic [1:0]  oa_size;
  logic [10:0] oa_source;
  logic [27:0] oa_address;
  logic [7:0]  oa_mask;
  logic [63:0] oa_data;
  logic        oa_corrupt;
  logic [2:0]  id_opcode;
  logic [1:0]  id_size;
  logic [10:0] id_source;
  logic [63:0] id_data;
  logic [119:0] a_out;
  logic [79:0]  d_out;
  assign a_out = {oa_opcode, oa_param, oa_size, oa_source, oa_address, oa_mask, oa_data, oa_corrupt};
  assign d_out = {id_opcode, id_size, id_source, id_data};

  // Outputs of the A_DEPTH=3 instance
  logic        c_in_a_ready, c_out_a_valid, c_out_d_ready, c_in_d_valid, c_int_out;
  logic [2:0]  ca_opcode, ca_param;
  logic [1:0]  ca_size;
  logic [10:0] ca_source;
  logic [27:0] ca_address;
  logic [7:0]  ca_mask;
  logic [63:0] ca_data;
  logic        ca_corrupt;
  logic [2:0]  cd_opcode;
  logic [1:0]  cd_size;
  logic [10:0] cd_source;
  logic [63:0] cd_data;
  logic [119:0] c_a_out;
  assign c_a_out = {ca_opcode, ca_param, ca_size, ca_source, ca_address, ca_mask, ca_data, ca_corrupt};

  plic_tl_buffer #(.A_DEPTH(2), .D_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
    .in_a_bits_opcode(ia_opcode), .in_a_bits_param(ia_param), .in_a_bits_size(ia_size),
    .in_a_bits_source(ia_source), .in_a_bits_address(ia_address), .in_a_bits_mask(ia_mask),
    .in_a_bits_data(ia_data), .in_a_bits_corrupt(ia_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_bits_opcode(oa_opcode), .out_a_bits_param(oa_param), .out_a_bits_size(oa_size),
    .out_a_bits_source(oa_source), .out_a_bits_address(oa_address), .out_a_bits_mask(oa_mask),
    .out_a_bits_data(oa_data), .out_a_bits_corrupt(oa_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_bits_opcode(od_opcode), .out_d_bits_size(od_size), .out_d_bits_source(od_source),
    .out_d_bits_data(od_data),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
    .in_d_bits_opcode(id_opcode), .in_d_bits_size(id_size), .in_d_bits_source(id_source),
    .in_d_bits_data(id_data),
    .int_in(int_in), .int_out(int_out)
  );

  plic_tl_buffer #(.A_DEPTH(3), .D_DEPTH(2)) dut3 (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(c_in_a_ready),
    .in_a_bits_opcode(ia_opcode), .in_a_bits_param(ia_param), .in_a_bits_size(ia_size),
    .in_a_bits_source(ia_source), .in_a_bits_address(ia_address), .in_a_bits_mask(ia_mask),
    .in_a_bits_data(ia_data), .in_a_bits_corrupt(ia_corrupt),
    .out_a_valid(c_out_a_valid), .out_a_ready(out_a_ready),
    .out_a_bits_opcode(ca_opcode), .out_a_bits_param(ca_param), .out_a_bits_size(ca_size),
    .out_a_bits_source(ca_source), .out_a_bits_address(ca_address), .out_a_bits_mask(ca_mask),
    .out_a_bits_data(ca_data), .out_a_bits_corrupt(ca_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(c_out_d_ready),
    .out_d_bits_opcode(od_opcode), .out_d_bits_size(od_size), .out_d_bits_source(od_source),
    .out_d_bits_data(od_data),
    .in_d_valid(c_in_d_valid), .in_d_ready(in_d_ready),
    .in_d_bits_opcode(cd_opcode), .in_d_bits_size(cd_size), .in_d_bits_source(cd_source),
    .in_d_bits_data(cd_data),
    .int_in(int_in), .int_out(c_int_out)
  );

  int checks = 0;
  int passed = 0;
  logic [119:0] a_q[$];
  logic [119:0] c_q[$];
  logic [79:0]  d_q[$];

  function automatic logic [119:0] rand_a();
    logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
    return r[119:0];
  endfunction

  function automatic logic [79:0] rand_d();
    logic [95:0] r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_a_valid = 1'b1; a_in = rand_a(); out_a_ready = 1'b1;
    out_d_valid = 1'b1; d_in = rand_d(); in_d_ready = 1'b1; int_in = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (in_a_ready !== 1'b0) $display("FAIL reset_in_a_ready: got %b want 0", in_a_ready);
      else passed++;
      checks++;
      if (out_a_valid !== 1'b0 || in_d_valid !== 1'b0)
        $display("FAIL reset_valid: got a=%b d=%b want 0", out_a_valid, in_d_valid);
      else passed++;
      checks++;
      if (a_out !== '0 || d_out !== '0) $display("FAIL reset_bits: got a=%h d=%h want 0", a_out, d_out);
      else passed++;
      @(posedge clock); #1;
    end
    reset = 1'b1; in_a_valid = 1'b0; out_d_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (in_a_ready !== 1'b1) $display("FAIL release_in_a_ready: got %b want 1", in_a_ready);
    else passed++;
    checks++;
    if (out_d_ready !== 1'b1) $display("FAIL release_out_d_ready: got %b want 1", out_d_ready);
    else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    logic [119:0] want_a;
    logic [79:0]  want_d;
    a_q.delete(); d_q.delete();
    a_in = {3'd4, 3'd0, 2'd3, 11'h015, 28'h0C02000, 8'hFF, 64'h0, 1'b0};
    d_in = {3'd1, 2'd3, 11'h015, 64'hDEAD_BEEF_0000_0001};
    in_a_valid = 1'b1; out_d_valid = 1'b1; out_a_ready = 1'b1; in_d_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (out_a_valid !== 1'b0 || in_d_valid !== 1'b0)
      $display("FAIL single_no_bypass: got a=%b d=%b want 0", out_a_valid, in_d_valid);
    else passed++;
    checks++;
    if (in_a_ready !== 1'b1 || out_d_ready !== 1'b1)
      $display("FAIL single_accept: got a=%b d=%b want 1", in_a_ready, out_d_ready);
    else passed++;
    a_q.push_back(a_in); d_q.push_back(d_in);
    @(posedge clock); #1;
    in_a_valid = 1'b0; out_d_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_a_valid !== 1'b1 || in_d_valid !== 1'b1)
      $display("FAIL single_valid_n1: got a=%b d=%b want 1", out_a_valid, in_d_valid);
    else passed++;
    want_a = a_q.pop_front();
    want_d = d_q.pop_front();
    checks++;
    if (a_out !== want_a) $display("FAIL single_a_bits: got %h want %h", a_out, want_a);
    else passed++;
    checks++;
    if (d_out !== want_d) $display("FAIL single_d_bits: got %h want %h", d_out, want_d);
    else passed++;
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (out_a_valid !== 1'b0 || in_d_valid !== 1'b0 || a_out !== '0)
      $display("FAIL single_drained: got a=%b d=%b bits=%h want 0", out_a_valid, in_d_valid, a_out);
    else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_fill();
    logic [119:0] want_a;
    int popped = 0;
    a_q.delete();
    out_a_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_a_valid = 1'b1; a_in = rand_a();
      @(negedge clock);
      checks++;
      if (in_a_ready !== 1'(k < 2)) $display("FAIL fill_ready_beat%0d: got %b want %b", k, in_a_ready, k < 2);
      else passed++;
      if (in_a_ready) a_q.push_back(a_in);
      @(posedge clock); #1;
    end
    out_a_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clock);
      if (cyc < 2) begin
        checks++;
        if (in_a_ready !== 1'(cyc == 1)) $display("FAIL fill_ready_rise%0d: got %b want %b", cyc, in_a_ready, cyc == 1);
        else passed++;
      end
      if (out_a_valid && out_a_ready) begin
        want_a = (a_q.size() != 0) ? a_q.pop_front() : '0;
        popped++;
        checks++;
        if (a_out !== want_a) $display("FAIL fill_order: got %h want %h", a_out, want_a);
        else passed++;
      end
      if (in_a_valid && in_a_ready) a_q.push_back(a_in);
      @(posedge clock); #1;
      if (in_a_valid && a_q.size() != 0 && cyc >= 1) in_a_valid = 1'b0;
    end
    checks++;
    if (popped !== 3 || a_q.size() !== 0) $display("FAIL fill_count: got %0d beats want 3", popped);
    else passed++;
  endtask

  task automatic test_stream();
    logic [119:0] want_a;
    a_q.delete(); c_q.delete();
    for (int cyc = 0; cyc < 306; cyc++) begin
      if (cyc < 100) begin
        in_a_valid = 1'b1; out_a_ready = 1'b1;
      end else if (cyc < 300) begin
        in_a_valid = 1'($urandom_range(0, 1)); out_a_ready = 1'($urandom_range(0, 2) != 0);
      end else begin
        in_a_valid = 1'b0; out_a_ready = 1'b1;
      end
      a_in = rand_a();
      @(negedge clock);
      checks++;
      if (in_a_ready !== (a_q.size() != 2) || c_in_a_ready !== (c_q.size() != 3))
        $display("FAIL stream_ready c%0d: got %b/%b want %b/%b", cyc, in_a_ready, c_in_a_ready,
                 a_q.size() != 2, c_q.size() != 3);
      else passed++;
      checks++;
      if (out_a_valid !== (a_q.size() != 0) || c_out_a_valid !== (c_q.size() != 0))
        $display("FAIL stream_valid c%0d: got %b/%b want %b/%b", cyc, out_a_valid, c_out_a_valid,
                 a_q.size() != 0, c_q.size() != 0);
      else passed++;
      if (out_a_valid && out_a_ready) begin
        want_a = (a_q.size() != 0) ? a_q.pop_front() : '0;
        checks++;
        if (a_out !== want_a) $display("FAIL stream_d2_bits c%0d: got %h want %h", cyc, a_out, want_a);
        else passed++;
      end
      if (c_out_a_valid && out_a_ready) begin
        want_a = (c_q.size() != 0) ? c_q.pop_front() : '0;
        checks++;
        if (c_a_out !== want_a) $display("FAIL stream_d3_bits c%0d: got %h want %h", cyc, c_a_out, want_a);
        else passed++;
      end
      if (in_a_valid && in_a_ready) a_q.push_back(a_in);
      if (in_a_valid && c_in_a_ready) c_q.push_back(a_in);
      @(posedge clock); #1;
    end
    checks++;
    if (a_q.size() != 0 || c_q.size() != 0)
      $display("FAIL stream_leftover: got %0d/%0d want 0/0", a_q.size(), c_q.size());
    else passed++;
  endtask

  task automatic test_midreset();
    out_a_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_a_valid = 1'b1; a_in = rand_a();
      @(posedge clock); #1;
    end
    in_a_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_a_ready !== 1'b0 || out_a_valid !== 1'b0)
      $display("FAIL midreset_during: got rdy=%b vld=%b want 0/0", in_a_ready, out_a_valid);
    else passed++;
    @(posedge clock); #1;
    reset = 1'b1; out_a_ready = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clock);
      checks++;
      if (out_a_valid !== 1'b0 || c_out_a_valid !== 1'b0 || a_out !== '0)
        $display("FAIL midreset_flush c%0d: got %b/%b want 0/0", cyc, out_a_valid, c_out_a_valid);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_int_throttle();
    logic [79:0] want_d;
    logic        ih [0:63];
    logic        want_int;
    d_q.delete();
    for (int cyc = 0; cyc < 54; cyc++) begin
      int_in = 1'(cyc >= 10 && cyc < 30);
      ih[cyc] = int_in;
      out_d_valid = (cyc < 48) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_d_ready  = (cyc < 48) ? 1'($urandom_range(0, 1)) : 1'b1;
      d_in = rand_d();
      @(negedge clock);
`ifdef PLIC_BUF_INT_SYNC_EN
      want_int = (cyc >= 2) ? ih[cyc-2] : 1'b0;
`else
      want_int = int_in;
`endif
      checks++;
      if (int_out !== want_int || c_int_out !== want_int)
        $display("FAIL int_out c%0d: got %b/%b want %b", cyc, int_out, c_int_out, want_int);
      else passed++;
      checks++;
      if (out_d_ready !== (d_q.size() != 2) || in_d_valid !== (d_q.size() != 0))
        $display("FAIL d_flow c%0d: got rdy=%b vld=%b want %b/%b", cyc, out_d_ready, in_d_valid,
                 d_q.size() != 2, d_q.size() != 0);
      else passed++;
      if (in_d_valid && in_d_ready) begin
        want_d = (d_q.size() != 0) ? d_q.pop_front() : '0;
        checks++;
        if (d_out !== want_d) $display("FAIL d_bits c%0d: got %h want %h", cyc, d_out, want_d);
        else passed++;
      end
      if (out_d_valid && out_d_ready) d_q.push_back(d_in);
      @(posedge clock); #1;
    end
    checks++;
    if (d_q.size() != 0) $display("FAIL d_leftover: got %0d want 0", d_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_midreset();
    test_int_throttle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
